// File: rtl/bch_enc_pkg.sv
// rtl/bch_enc_pkg.sv - shared BCH(141,127) encoder constants and helpers
package bch_enc_pkg;

  localparam int BCH_DW     = 127;
  localparam int BCH_CW     = 141;
  localparam int BCH_PARITY = 14;

  // Ceiling log2, never below 1 so it can size an index or pointer directly
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_enc_fifo.sv
// rtl/bch_enc_fifo.sv - synchronous codeword/ID FIFO with occupancy count
module bch_enc_fifo
  import bch_enc_pkg::*;
#(
  parameter int W     = 143,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [W-1:0]    push_data,
  input  logic            pop,
  output logic [W-1:0]    head,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam int PW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // An empty FIFO presents zeros so stale entries never leak onto the output
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array is written only, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bch_enc_arbiter.sv
// rtl/bch_enc_arbiter.sv - round-robin sharing of one BCH encoder core (BCH_ENC_ARB_STATS_EN adds stat_cnt)
module bch_enc_arbiter
  import bch_enc_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DW         = BCH_DW,
  parameter int CW         = BCH_CW,
  parameter int ENC_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [DW-1:0]      enc_in,
  input  logic [CW-1:0]      enc_out,
  output logic               cw_valid,
  input  logic               cw_ready,
  output logic [CW-1:0]      cw_data,
  output logic [IDW-1:0]     cw_id,
  output logic               busy
`ifdef BCH_ENC_ARB_STATS_EN
  , output logic [NREQ*16-1:0] stat_cnt
`endif
);

  localparam int CNTW = clog2(FIFO_DEPTH + 1);

  generate
    if (FIFO_DEPTH < ENC_LAT + 2) begin : g_bad_depth
      $error("FIFO_DEPTH must be at least ENC_LAT+2");
    end
    if (CW != DW + BCH_PARITY) begin : g_bad_cw
      $error("CW must equal DW plus the parity width");
    end
  endgenerate

  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            found;
  logic            hs;
  logic            credit_ok;
  logic [CNTW-1:0] inflight;
  logic [CNTW-1:0] fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ENC_LAT:0] pipe_v;
  logic [IDW-1:0]  pipe_id [0:ENC_LAT];
  logic            pop;

  // In-flight messages: the enc_in stage plus each encoder latency stage
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ENC_LAT; i++) inflight = inflight + CNTW'(pipe_v[i]);
  end

  // Credit exists when FIFO and pipeline together leave room for one more
  assign credit_ok = ((CNTW+1)'(fifo_count) + (CNTW+1)'(inflight)) < (CNTW+1)'(FIFO_DEPTH);

  // Round-robin search starting at rr_ptr, wrapping past NREQ-1
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    if (credit_ok) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
          found   = 1'b1;
          gnt_idx = IDW'((int'(rr_ptr) + k) % NREQ);
        end
      end
    end
    if (found) gnt = NREQ'(1) << gnt_idx;
  end

  assign req_ready = gnt;
  assign hs        = found;

  // Pointer moves past the winner only on a handshake
  always_ff @(posedge clk) begin
    if (rst)     rr_ptr <= '0;
    else if (hs) rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Encoder input register holds its last message while idle
  always_ff @(posedge clk) begin
    if (rst)     enc_in <= '0;
    else if (hs) enc_in <= req_data[int'(gnt_idx)*DW +: DW];
  end

  // Valid/ID shift pipe tracking which requester owns each encoder stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i <= ENC_LAT; i++) pipe_id[i] <= '0;
    end else begin
      pipe_v[0]  <= hs;
      pipe_id[0] <= gnt_idx;
      for (int i = 1; i <= ENC_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign pop = cw_valid & cw_ready;

  bch_enc_fifo #(
    .W     (CW + IDW),
    .DEPTH (FIFO_DEPTH),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_v[ENC_LAT]),
    .push_data ({pipe_id[ENC_LAT], enc_out}),
    .pop       (pop),
    .head      ({cw_id, cw_data}),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cw_valid = ~fifo_empty;
  assign busy     = (inflight != '0) | (fifo_count != '0);

`ifdef BCH_ENC_ARB_STATS_EN
  // Per-requester accepted-message counters, saturating at all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && stat_cnt[i*16 +: 16] != 16'hFFFF)
          stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bch_enc_arbiter.sv
// tb/tb_bch_enc_arbiter.sv - directed self-checking bench for bch_enc_arbiter
module tb_bch_enc_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 127;
  localparam int CW   = 141;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [DW-1:0]      enc_in;
  logic [CW-1:0]      enc_out;
  logic               cw_valid;
  logic               cw_ready;
  logic [CW-1:0]      cw_data;
  logic [IDW-1:0]     cw_id;
  logic               busy;
`ifdef BCH_ENC_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  bch_enc_arbiter #(
    .NREQ(NREQ), .DW(DW), .CW(CW), .ENC_LAT(1), .FIFO_DEPTH(4), .IDW(IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .enc_in    (enc_in),
    .enc_out   (enc_out),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .cw_id     (cw_id),
    .busy      (busy)
`ifdef BCH_ENC_ARB_STATS_EN
    , .stat_cnt (stat_cnt)
`endif
  );

  // Systematic encoder reference: message followed by 14-bit remainder
  function automatic logic [CW-1:0] cw_of(input logic [DW-1:0] m);
    logic [13:0] p;
    logic        fb;
    p = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = m[i] ^ p[13];
      p  = {p[12:0], 1'b0} ^ (fb ? 14'h0377 : 14'h0000);
    end
    return {m, p};
  endfunction

  // Encoder core stand-in with one cycle of latency
  always @(posedge clk) enc_out <= cw_of(enc_in);

  typedef struct packed {
    logic [CW-1:0]  cw;
    logic [IDW-1:0] id;
  } item_t;

  int          checks = 0;
  int          errors = 0;
  item_t       exp_q[$];
  logic [DW-1:0] cur_msg [NREQ];
  logic [DW-1:0] last_msg;
  logic          have_last = 1'b0;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = cur_msg[i];
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard any pop about to happen, then advance one clock
  task automatic tick();
    item_t it;
    if (cw_valid === 1'b1 && cw_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_without_expected_item", {159'd0, cw_valid}, 160'd0);
      end else begin
        it = exp_q.pop_front();
        chk("cw_data", cw_data, it.cw);
        chk("cw_id", cw_id, it.id);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One directed cycle: drive, check grant against hand-computed value, clock
  task automatic cyc(input logic [NREQ-1:0] v, input logic rdy,
                     input logic [NREQ-1:0] exp_rdy, input string tag);
    int gid;
    req_valid = v;
    cw_ready  = rdy;
    #1;
    if (have_last) begin
      chk({tag, "_enc_in"}, enc_in, last_msg);
      have_last = 1'b0;
    end
    chk({tag, "_req_ready"}, req_ready, exp_rdy);
    gid = -1;
    for (int k = 0; k < NREQ; k++) if (exp_rdy[k]) gid = k;
    if (gid >= 0) begin
      exp_q.push_back({cw_of(cur_msg[gid]), IDW'(gid)});
      last_msg = cur_msg[gid];
    end
    tick();
    if (gid >= 0) begin
      cur_msg[gid] = cur_msg[gid] + 127'h1_0000_0000_0000_0003;
      have_last = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 30 && busy === 1'b1; n++) cyc('0, 1'b1, '0, tag);
    chk({tag, "_busy"}, busy, 160'd0);
    chk({tag, "_queue_left"}, exp_q.size(), 160'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    cw_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    have_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    cw_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) cur_msg[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_cw_valid", cw_valid, 160'd0);
    chk("rst_busy", busy, 160'd0);
    chk("rst_enc_in", enc_in, 160'd0);
    chk("rst_cw_data", cw_data, 160'd0);
    chk("rst_cw_id", cw_id, 160'd0);

    cyc(4'b0001, 1'b1, 4'b0001, "t1_grant");
    chk("t1_busy_t1", busy, 160'd1);
    chk("t1_valid_t1", cw_valid, 160'd0);
    cyc(4'b0000, 1'b1, 4'b0000, "t1_w1");
    chk("t1_valid_t2", cw_valid, 160'd0);
    cyc(4'b0000, 1'b1, 4'b0000, "t1_w2");
    chk("t1_valid_t3", cw_valid, 160'd1);
    chk("t1_data_t3", cw_data, 160'd0);
    chk("t1_id_t3", cw_id, 160'd0);
    drain("t1_drain");

    do_reset();
    cur_msg[0] = 127'h1_2345_6789_ABCD_EF01;
    cur_msg[1] = 127'h7ABC_DEF0_1234_5678_9ABC_DEF0_1234_567;
    cur_msg[2] = 127'hFFFF_FFFF_FFFF_FFFF;
    cur_msg[3] = {1'b1, 126'd3};
    cyc(4'b1111, 1'b1, 4'b0001, "t2_g0");
    cyc(4'b1110, 1'b1, 4'b0010, "t2_g1");
    cyc(4'b1100, 1'b1, 4'b0100, "t2_g2");
    cyc(4'b1000, 1'b1, 4'b1000, "t2_g3");
    drain("t2_drain");

    cyc(4'b1010, 1'b0, 4'b0010, "t3_g1");
    cyc(4'b1010, 1'b0, 4'b1000, "t3_g2");
    cyc(4'b1010, 1'b0, 4'b0010, "t3_g3");
    cyc(4'b1010, 1'b0, 4'b1000, "t3_g4");
    for (int n = 0; n < 3; n++) begin
      cyc(4'b1010, 1'b0, 4'b0000, "t3_stall");
      chk("t3_stall_valid", cw_valid, 160'd1);
      chk("t3_stall_head", cw_data, exp_q[0].cw);
    end
    cyc(4'b1010, 1'b1, 4'b0000, "t3_pop1");
    cyc(4'b1010, 1'b1, 4'b0010, "t3_resume1");
    cyc(4'b1000, 1'b1, 4'b1000, "t3_resume3");
    drain("t3_drain");

    cyc(4'b0100, 1'b1, 4'b0100, "t4_a");
    cyc(4'b0100, 1'b1, 4'b0100, "t4_b");
    cyc(4'b0101, 1'b1, 4'b0001, "t4_wrap");
    cyc(4'b0101, 1'b1, 4'b0100, "t4_c");
    cyc(4'b0101, 1'b1, 4'b0001, "t4_d");
    cyc(4'b0101, 1'b1, 4'b0100, "t4_e");
    cyc(4'b0001, 1'b1, 4'b0001, "t4_f");
    drain("t4_drain");

    cyc(4'b0010, 1'b0, 4'b0010, "t5_g1");
    cyc(4'b0010, 1'b0, 4'b0010, "t5_g2");
    cyc(4'b0010, 1'b0, 4'b0010, "t5_g3");
    cyc(4'b0010, 1'b0, 4'b0010, "t5_g4");
    chk("t5_pre_busy", busy, 160'd1);
    do_reset();
    chk("t5_cw_valid", cw_valid, 160'd0);
    chk("t5_busy", busy, 160'd0);
    chk("t5_enc_in", enc_in, 160'd0);
    chk("t5_cw_data", cw_data, 160'd0);
    cyc(4'b1001, 1'b1, 4'b0001, "t5_ptr0");
    cyc(4'b1000, 1'b1, 4'b1000, "t5_next");
    drain("t5_drain");

`ifdef BCH_ENC_ARB_STATS_EN
    do_reset();
    for (int n = 0; n < 5; n++) cyc(4'b0010, 1'b1, 4'b0010, "st_g");
    drain("st_drain");
    chk("stat_req0", stat_cnt[0 +: 16], 160'd0);
    chk("stat_req1", stat_cnt[16 +: 16], 160'd5);
    chk("stat_req2", stat_cnt[32 +: 16], 160'd0);
    chk("stat_req3", stat_cnt[48 +: 16], 160'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
